// File: rtl/ras.sv
// Return address stack: a circular stack of predicted return targets.
// It also checkpoints and restores the top-of-stack on a retire-side flush.
module ras #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTRW  = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [63:0]     pc_f0_i,
  input  logic            btb_hit_f0_i,
  input  logic [2:0]      btb_brpos_f0_i,
  input  logic [1:0]      btb_rasctl_f0_i,
  input  logic            stall_f0_i,
  input  logic            flush_rt_i,
  input  logic [PTRW-1:0] ckpt_tos_rt_i,
  input  logic [PTRW:0]   ckpt_cnt_rt_i,
  output logic            ras_vld_f0_o,
  output logic [63:0]     ras_tar_f0_o,
  output logic [PTRW-1:0] ras_tos_f0_o,
  output logic [PTRW:0]   ras_cnt_f0_o,
  output logic            ras_ovf_o,
  output logic            ras_udf_o
);

  localparam int unsigned CW = PTRW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  logic [63:0]     entry_q [DEPTH];
  logic [PTRW-1:0] tos_q, tos_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_d, udf_d;
  logic            wr_en_c;
  logic [PTRW-1:0] wr_idx_c;
  logic [63:0]     ret_c;
  logic            op_v_c;
  logic            unused_pc_c;

  // Return address is the instruction after the branch slot; wraps at 2^64.
  always_comb ret_c = {pc_f0_i[63:5], btb_brpos_f0_i, 2'b00} + 64'd4;
  assign unused_pc_c = ^pc_f0_i[4:0];

  assign op_v_c = btb_hit_f0_i & ~stall_f0_i & ~flush_rt_i & (btb_rasctl_f0_i != 2'b00);

  // Next-state: a flush wins over any fetch-side operation.
  always_comb begin
    tos_d    = tos_q;
    cnt_d    = cnt_q;
    wr_en_c  = 1'b0;
    wr_idx_c = tos_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    if (flush_rt_i) begin
      tos_d = ckpt_tos_rt_i;
      cnt_d = (ckpt_cnt_rt_i > FULL) ? FULL : ckpt_cnt_rt_i;
    end else if (op_v_c) begin
      case (btb_rasctl_f0_i)
        OP_PUSH: begin
          tos_d    = tos_q + PTRW'(1);
          wr_en_c  = 1'b1;
          wr_idx_c = tos_q + PTRW'(1);
          if (cnt_q == FULL) ovf_d = 1'b1;
          else               cnt_d = cnt_q + CW'(1);
        end
        OP_POP: begin
          if (cnt_q == '0) begin
            udf_d = 1'b1;
          end else begin
            tos_d = tos_q - PTRW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
        OP_SWAP: begin
          wr_en_c = 1'b1;
          if (cnt_q == '0) cnt_d = CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tos_q     <= '0;
      cnt_q     <= '0;
      ras_ovf_o <= 1'b0;
      ras_udf_o <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
    end else begin
      tos_q     <= tos_d;
      cnt_q     <= cnt_d;
      ras_ovf_o <= ovf_d;
      ras_udf_o <= udf_d;
      if (wr_en_c) entry_q[wr_idx_c] <= ret_c;
    end
  end

  // Prediction outputs come from registered state only; no same-cycle bypass.
  assign ras_vld_f0_o = (cnt_q != '0);
  assign ras_tar_f0_o = ras_vld_f0_o ? entry_q[tos_q] : 64'd0;
  assign ras_tos_f0_o = tos_q;
  assign ras_cnt_f0_o = cnt_q;

endmodule
